// File: rtl/jtframe_dualram_arb_pkg.sv
// Shared types for the dual-port RAM port-0 arbiter.
// State encoding and requester index constants.
package jtframe_dualram_arb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/jtframe_rr_arb2.sv
// Two-way round-robin grant; pointer names the side
// that wins when both sides request in the same cycle.
module jtframe_rr_arb2
    import jtframe_dualram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr == REQ_B) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // after any grant the other side gets priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= REQ_A;
        end else if (|gnt) begin
            ptr <= gnt[REQ_A] ? REQ_B : REQ_A;
        end
    end

endmodule

// File: rtl/jtframe_dualram_arb.sv
// Port-0 sequencer for a jtframe dual-port RAM: clear sweep
// plus round-robin sharing between requesters A and B.
module jtframe_dualram_arb
    import jtframe_dualram_arb_pkg::*;
#(
    parameter int              dw      = 8,
    parameter int              aw      = 10,
    parameter bit              CLR_EN  = 1'b1,
    parameter logic [dw-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          clr_busy,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [aw-1:0] addr_a,
    input  logic [dw-1:0] din_a,
    output logic          ack_a,
    output logic          dok_a,
    output logic [dw-1:0] dout_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [aw-1:0] addr_b,
    input  logic [dw-1:0] din_b,
    output logic          ack_b,
    output logic          dok_b,
    output logic [dw-1:0] dout_b,
    output logic [aw-1:0] ram_addr,
    output logic [dw-1:0] ram_data,
    output logic          ram_we,
    input  logic [dw-1:0] ram_q
);

    localparam logic [aw:0] CNT_ONE = {{aw{1'b0}}, 1'b1};

    state_t        state, state_nx;
    logic [aw:0]   cnt, cnt_nx;
    logic [aw-1:0] addr_hold;
    logic [dw-1:0] data_hold;
    logic [1:0]    gnt;
    logic          rd_a, rd_b;
    logic [dw-1:0] q_a, q_b;

    jtframe_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_RUN),
        .req   ({req_b, req_a}),
        .gnt   (gnt)
    );

    assign ack_a    = gnt[REQ_A];
    assign ack_b    = gnt[REQ_B];
    assign clr_busy = (state == ST_CLEAR);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ram_addr = addr_hold;
        ram_data = data_hold;
        ram_we   = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                ram_addr = cnt[aw-1:0];
                ram_data = CLR_VAL;
                ram_we   = 1'b1;
                cnt_nx   = cnt + CNT_ONE;
                // carry into bit aw marks the last word written
                if (cnt_nx[aw]) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = '0;
                end
                if (ack_a) begin
                    ram_addr = addr_a;
                    ram_data = din_a;
                    ram_we   = we_a;
                end else if (ack_b) begin
                    ram_addr = addr_b;
                    ram_data = din_b;
                    ram_we   = we_b;
                end
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLR_EN ? ST_CLEAR : ST_RUN;
            cnt       <= '0;
            addr_hold <= '0;
            data_hold <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            addr_hold <= ram_addr;
            data_hold <= ram_data;
        end
    end

    // read return: RAM q is valid the cycle after the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a <= 1'b0;
            rd_b <= 1'b0;
            q_a  <= '0;
            q_b  <= '0;
        end else begin
            rd_a <= ack_a & ~we_a;
            rd_b <= ack_b & ~we_b;
            if (rd_a) q_a <= ram_q;
            if (rd_b) q_b <= ram_q;
        end
    end

    assign dok_a  = rd_a;
    assign dok_b  = rd_b;
    assign dout_a = rd_a ? ram_q : q_a;
    assign dout_b = rd_b ? ram_q : q_b;

endmodule

// File: tb/tb_jtframe_dualram_arb.sv
// Bench for jtframe_dualram_arb with a behavioural RAM on port 0
// and a read-data scoreboard per requester.
module tb_jtframe_dualram_arb;

    localparam int         DW = 8;
    localparam int         AW = 4;
    localparam int         N  = 16;
    localparam logic [7:0] CV = 8'h5A;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          clr_busy;
    logic          req_a = 1'b0, we_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] din_a = '0;
    logic          ack_a, dok_a;
    logic [DW-1:0] dout_a;
    logic          req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] din_b = '0;
    logic          ack_b, dok_b;
    logic [DW-1:0] dout_b;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] sh [N];
    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];
    logic [DW-1:0] last_a = '0, last_b = '0;
    logic          pend_a = 1'b0, pend_b = 1'b0;
    int            fill_req = 0, fill_seen = 0;
    int            checks = 0, errors = 0;

    jtframe_dualram_arb #(
        .dw(DW), .aw(AW), .CLR_EN(1'b1), .CLR_VAL(CV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .clr_busy(clr_busy),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .ack_a(ack_a), .dok_a(dok_a), .dout_a(dout_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .ack_b(ack_b), .dok_b(dok_b), .dout_b(dout_b),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // single-port view of the RAM, read-before-write
    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_data;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fill_req != fill_seen) begin
            for (int k = 0; k < N; k++) sh[k] = CV;
            fill_seen = fill_req;
        end
        if (!rst_n) begin
            pend_a = 1'b0;
            pend_b = 1'b0;
            q_a.delete();
            q_b.delete();
            last_a = '0;
            last_b = '0;
        end else begin
            chk("dok_a", dok_a, pend_a);
            chk("dok_b", dok_b, pend_b);
            if (dok_a && q_a.size() > 0) begin
                last_a = q_a.pop_front();
                chk("dout_a", dout_a, last_a);
            end else if (!dok_a) begin
                chk("hold_a", dout_a, last_a);
            end
            if (dok_b && q_b.size() > 0) begin
                last_b = q_b.pop_front();
                chk("dout_b", dout_b, last_b);
            end else if (!dok_b) begin
                chk("hold_b", dout_b, last_b);
            end
            if (clr_busy) chk("clr_noack", {ack_a, ack_b}, 2'b00);
            pend_a = ack_a && !we_a;
            pend_b = ack_b && !we_b;
            if (pend_a) q_a.push_back(sh[addr_a]);
            if (pend_b) q_b.push_back(sh[addr_b]);
            if (ack_a && we_a) sh[addr_a] = din_a;
            if (ack_b && we_b) sh[addr_b] = din_b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("sw_busy", clr_busy, 1);
            chk("sw_we", ram_we, 1);
            chk("sw_addr", ram_addr, i);
            chk("sw_data", ram_data, CV);
        end
    endtask

    task automatic sweep_full();
        sweep(N);
        @(negedge clk);
        chk("sw_done", clr_busy, 0);
    endtask

    task automatic set_a(input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_a = r; we_a = w; addr_a = a; din_a = d;
    endtask

    task automatic set_b(input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_b = r; we_b = w; addr_b = a; din_b = d;
    endtask

    logic          t4_we [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] t4_ad [4]   = '{4'd8, 4'd8, 4'd9, 4'd9};
    logic [DW-1:0] t4_dt [4]   = '{8'hC4, 8'h00, 8'h99, 8'h00};

    initial begin
        fill_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", clr_busy, 1);
        chk("rst_ack", {ack_a, ack_b}, 2'b00);
        chk("rst_dok", {dok_a, dok_b}, 2'b00);
        chk("rst_dout", {dout_a, dout_b}, 16'h0000);
        chk("rst_addr", ram_addr, 0);
        step();
        rst_n = 1'b1;
        sweep_full();

        // read after the power-on sweep
        step(); set_a(1, 0, 4'd7, 8'h00);
        @(negedge clk);
        chk("t1_ack_a", ack_a, 1);
        chk("t1_ack_b", ack_b, 0);
        chk("t1_addr", ram_addr, 7);
        chk("t1_we", ram_we, 0);
        step(); set_a(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        chk("t1_dout", dout_a, CV);
        chk("t1_addr_hold", ram_addr, 7);
        chk("t1_idle_we", ram_we, 0);

        // write then read back
        step(); set_a(1, 1, 4'd3, 8'h33);
        @(negedge clk);
        chk("t2_ack_w", ack_a, 1);
        chk("t2_we", ram_we, 1);
        chk("t2_data", ram_data, 8'h33);
        chk("t2_addr", ram_addr, 3);
        step(); we_a = 1'b0;
        @(negedge clk);
        chk("t2_ack_r", ack_a, 1);
        chk("t2_we_r", ram_we, 0);
        step(); set_a(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        chk("t2_dout", dout_a, 8'h33);

        // B alone: back-to-back grants
        for (int i = 0; i < 4; i++) begin
            step(); set_b(1, t4_we[i], t4_ad[i], t4_dt[i]);
            @(negedge clk);
            chk("t4_ack_b", ack_b, 1);
            chk("t4_ack_a", ack_a, 0);
        end
        step(); set_b(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        chk("t4_dout_b", dout_b, 8'h99);

        // contention: pointer is back on A
        step();
        set_a(1, 0, 4'd3, 8'h00);
        set_b(1, 0, 4'd8, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t3_ack_a", ack_a, (i % 2) == 0);
            chk("t3_ack_b", ack_b, (i % 2) == 1);
            if (i < 5) step();
        end
        step();
        set_a(0, 0, 4'd0, 8'h00);
        set_b(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        chk("t3_dout_b", dout_b, 8'hC4);
        chk("t3_hold_a", dout_a, 8'h33);

        // clr while A is active
        step(); set_a(1, 1, 4'd7, 8'h77);
        @(negedge clk);
        chk("t5_ack_w", ack_a, 1);
        step(); we_a = 1'b0; clr = 1'b1;
        @(negedge clk);
        chk("t5_ack_clr", ack_a, 1);
        chk("t5_busy_lo", clr_busy, 0);
        step(); clr = 1'b0; fill_req++;
        sweep_full();
        chk("t5_ack_run", ack_a, 1);
        step(); set_a(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        chk("t5_dout", dout_a, CV);

        // reset mid-sweep at counter 5
        step(); clr = 1'b1;
        step(); clr = 1'b0; fill_req++;
        sweep(6);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy", clr_busy, 1);
        chk("t6_addr", ram_addr, 0);
        chk("t6_dout", {dout_a, dout_b}, 16'h0000);
        chk("t6_dok", {dok_a, dok_b}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; fill_req++;
        sweep_full();

        // reset with a read in flight
        step(); set_a(1, 0, 4'd2, 8'h00);
        @(negedge clk);
        chk("t6_ack_rd", ack_a, 1);
        #1 rst_n = 1'b0; set_a(0, 0, 4'd0, 8'h00);
        #1;
        chk("t6_rd_dok", dok_a, 0);
        chk("t6_rd_ack", ack_a, 0);
        chk("t6_rd_busy", clr_busy, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; fill_req++;
        sweep_full();
        step(); set_a(1, 0, 4'd2, 8'h00);
        @(negedge clk);
        chk("t6_ack_after", ack_a, 1);
        step(); set_a(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        chk("t6_dout_after", dout_a, CV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_dualram_arb.md
Name: jtframe_dualram_arb

Overview:
- Arbiter and sequencer for port 0 of a jtframe dual-port RAM.
- Shares that single port between two requesters (A, B) using round-robin priority.
- Runs a clear sweep that fills the whole RAM with a constant, after reset and on command.
- Port 1 of the RAM stays with the other clock domain; this block never touches it.

Parameters:
dw, 8, data width; must match the RAM instance.
aw, 10, address width; the RAM holds 2**aw words.
CLR_EN, 1, 1 = run a clear sweep automatically after reset.
CLR_VAL, 0, dw-bit value written by every clear sweep.

Ports:
clk  in  1  system clock; the RAM port 0 uses the same clock with cen0=1.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  one-cycle pulse that starts a clear sweep.
clr_busy  out  1  high while a sweep is running.
req_a  in  1  requester A access request (level).
we_a  in  1  A write enable, qualified by req_a.
addr_a  in  aw  A address.
din_a  in  dw  A write data.
ack_a  out  1  A access accepted this cycle (combinational).
dok_a  out  1  A read data valid (one-cycle pulse).
dout_a  out  dw  A read data.
req_b, we_b, addr_b, din_b, ack_b, dok_b, dout_b: same as the A set, for requester B.
ram_addr  out  aw  to RAM addr0.
ram_data  out  dw  to RAM data0.
ram_we  out  1  to RAM we0.
ram_q  in  dw  from RAM q0; RAM latency is 1 cycle, read-before-write.

Behaviour:
- States: CLEAR and RUN.
- Reset, asynchronous:
  - state = CLEAR if CLR_EN, else RUN.
  - Clear counter = 0; priority pointer = A.
  - All acks and doks = 0; dout_a = dout_b = 0; held data = 0.
  - clr_busy = CLR_EN.
- CLEAR:
  - Each cycle: ram_addr = counter, ram_data = CLR_VAL, ram_we = 1, counter += 1.
  - After writing address 2**aw-1, go to RUN next cycle. Total sweep length is exactly 2**aw cycles.
  - No acks are issued during CLEAR; requests wait, and requesters must hold them.
  - clr asserted during CLEAR is ignored (no restart).
- RUN, grant in cycle N:
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the side named by the priority pointer.
  - The pointer moves to the non-granted side after every grant.
- Grant outputs, all combinational in cycle N:
  - ack_x = 1 for the granted side.
  - ram_addr = addr_x, ram_data = din_x, ram_we = we_x.
  - With no grant: ram_we = 0, ram_addr holds its last value.
- Throughput: one access per cycle. A requester holding req_x gets back-to-back acks when it is the only requester, or alternating acks under contention.
- Requester contract: after ack_x, the requester either presents the next access or drops req_x in the next cycle.
- Read completion, for a granted access with we_x = 0:
  - dok_x = 1 in cycle N+1.
  - dout_x = ram_q during N+1; ram_q is registered and held afterwards until the next dok_x.
  - Writes never produce dok.
- Read of an address written in the same cycle returns the old contents (RAM is read-before-write). The following access returns the new contents.
- clr in RUN: go to CLEAR next cycle with counter = 0.
  - A grant in that same cycle still completes, including its dok.
  - clr_busy rises the cycle after clr.
- Reset mid-sweep or mid-read: the sweep is aborted and pending doks are dropped. Sequencing restarts per the reset values.
- Wrap: the counter is aw+1 bits wide. Sweep termination is detected on bit aw, so there is no wrap-around rewrite.

Decomposition:
- Shared package holds the state encoding (CLEAR, RUN) and the requester index constants (A=0, B=1).
- One natural sub-module, jtframe_rr_arb2: a 2-way round-robin grant with pointer register, reused elsewhere.
- The clear counter and the read-return pipe stay in the top module.

Test Plan:
1. Reset with CLR_EN=1, aw=4, CLR_VAL=8'h5A: clr_busy high for exactly 16 cycles, with ram_we=1 for addresses 0..15. Then A reads address 7: dok_a one cycle after ack_a, dout_a=8'h5A.
2. A writes 8'h33 to address 3, then reads address 3 on the next cycle: ack_a on both cycles, dout_a=8'h33. A write and read of address 3 in the same grant is not possible (single port).
3. req_a and req_b held for 6 cycles after reset, pointer=A: acks run A,B,A,B,A,B. Each read dok follows its own ack by 1 cycle; dout_a and dout_b each hold their values between doks.
4. Only req_b held for 4 cycles: ack_b high on 4 consecutive cycles, ack_a never asserted.
5. clr pulse while A is requesting in RUN: the grant in the clr cycle completes with its dok. No further acks for 2**aw cycles, and A's request is acked on the first RUN cycle after the sweep.
6. rst_n dropped mid-sweep at counter=5 and mid-read: all outputs return to reset values immediately, no stray dok, and the sweep restarts from 0 after release.
